// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared input-FSM state encodings and default data width for the I/O port bridge
package io_bridge_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [1:0] {IN_IDLE, IN_LOAD, IN_WAIT} in_state_t;
endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: synchronous FIFO with registered head word, no fall-through
//   clock/clear  : clock, asynchronous active-low reset
//   push/din     : write request and word; accepted when not full or popping this cycle
//   pop          : read request; ignored when empty
//   dout         : head word (register read, stable until popped)
//   full/empty/count : occupancy status, count 0..DEPTH
module io_sync_fifo
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    // Storage is reset so the head word reads as zero out of reset
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: device-side end of the CPU I/O ports (Out-port FIFO drain, In-port delivery FSM)
//   clock/clear          : clock, asynchronous active-low reset
//   out_port_we/data     : Out-port write capture into the FIFO
//   tx_valid/data/ready  : FIFO drain to the external consumer
//   rx_valid/data/ready  : words from the external producer
//   in_port_strobe/data  : In-port register load strobe and word
//   in_port_read         : CPU consumed the In-port word
//   in_port_full         : word delivered, not yet read
//   out_count            : FIFO occupancy
//   out_overflow         : sticky dropped-write flag
//   loopback             : only with IO_BRIDGE_LOOPBACK_EN; FIFO head feeds the input FSM
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OUT_DEPTH = 4,
    localparam int CW = $clog2(OUT_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             out_port_we,
    input  logic [WIDTH-1:0] out_port_data,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_ready,
    output logic             in_port_strobe,
    output logic [WIDTH-1:0] in_port_data,
    input  logic             in_port_read,
    output logic             in_port_full,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
`ifdef IO_BRIDGE_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);
    in_state_t state, state_n;
    logic lb, fifo_full, fifo_empty, fifo_pop, idle, fsm_valid, accept;
    logic [WIDTH-1:0] head;
`ifdef IO_BRIDGE_LOOPBACK_EN
    // Registered so a loopback change applies from the next cycle
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) lb <= 1'b0;
        else        lb <= loopback;
    end
`else
    assign lb = 1'b0;
`endif
    // Gated with clear so rx_ready reads 0 while reset is held
    assign idle      = (state == IN_IDLE) && clear;
    assign fsm_valid = lb ? !fifo_empty : rx_valid;
    assign accept    = idle && fsm_valid;
    assign rx_ready  = idle && !lb;
    assign tx_valid  = !fifo_empty && !lb;
    assign tx_data   = head;
    assign fifo_pop  = lb ? accept : (tx_valid && tx_ready);
    assign in_port_strobe = state == IN_LOAD;
    assign in_port_full   = state == IN_WAIT;
    io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_fifo (
        .clock(clock),
        .clear(clear),
        .push(out_port_we),
        .pop(fifo_pop),
        .din(out_port_data),
        .dout(head),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(out_count)
    );
    always_comb begin
        state_n = state;
        case (state)
            IN_IDLE: state_n = accept ? IN_LOAD : IN_IDLE;
            IN_LOAD: state_n = IN_WAIT;
            IN_WAIT: state_n = in_port_read ? IN_IDLE : IN_WAIT;
            default: state_n = IN_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state        <= IN_IDLE;
            in_port_data <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) in_port_data <= lb ? head : rx_data;
            if (out_port_we && fifo_full && !fifo_pop) out_overflow <= 1'b1;
        end
    end
endmodule
